// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the Alu arbitration slice.
//  - Alu opcode values as driven on alu_op_code.
//  - Arbiter FSM state encoding.
//  - is_div_op(): true for the opcodes whose divisor may be zero.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SUB  = 5'h01;
  localparam logic [4:0] OP_OR   = 5'h02;
  localparam logic [4:0] OP_AND  = 5'h03;
  localparam logic [4:0] OP_SG   = 5'h04;
  localparam logic [4:0] OP_SL   = 5'h05;
  localparam logic [4:0] OP_SE   = 5'h06;
  localparam logic [4:0] OP_MULT = 5'h07;
  localparam logic [4:0] OP_DIV  = 5'h08;
  localparam logic [4:0] OP_MOD  = 5'h09;
  localparam logic [4:0] OP_NOT  = 5'h10;
  localparam logic [4:0] OP_JL   = 5'h12;
  localparam logic [4:0] OP_SW   = 5'h19;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// alu_rr_pick: combinational round-robin picker.
//  Chooses the first set bit of valid at or after rr_ptr, wrapping NREQ-1 -> 0.
// Ports:
//  valid   in   NREQ   request vector
//  rr_ptr  in   IW     highest-priority index this cycle
//  grant   out  NREQ   one-hot winner (all zero when nothing is valid)
//  idx     out  IW     binary index of the winner (0 when nothing is valid)
//  any     out  1      at least one request is valid
module alu_rr_pick
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int          j;
  logic [IW-1:0] jj;

  // Scan from the farthest offset down to offset 0 so the candidate
  // closest to rr_ptr is the last one written and therefore wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = IW'(j);
      if (valid[jj]) begin
        grant     = '0;
        grant[jj] = 1'b1;
        idx       = jj;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational Alu between NREQ requesters.
//  Round-robin grant in IDLE, operands latched and held on alu_* for ALU_LAT
//  cycles, result captured into rsp_data and returned to the owner.
// Handshake rules (both sides): a transfer happens on a rising clk edge where
//  valid and ready are both 1. req_ready is a one-hot grant, only in IDLE.
//  rsp_valid is one-hot to the owner; rsp_data/rsp_err are held until the
//  owner's rsp_ready is seen. rsp_ready of any other requester is ignored.
// Optional feature: define ALU_DIVZERO_TRAP_EN to answer DIV/MOD by zero
//  directly (all-ones data, rsp_err=1) without using the Alu.
// Ports:
//  clk, rst_n                 clock, asynchronous active-low reset
//  req_valid/req_ready        per-requester request handshake
//  req_op/req_a/req_b         packed per-requester opcode and operands
//  rsp_valid/rsp_ready        per-requester response handshake
//  rsp_data/rsp_err           shared response bus
//  alu_op_code/alu_data1/2    latched operands to the Alu
//  alu_result                 Alu combinational result
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int W       = 32,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [5*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_err,
  output logic [4:0]        alu_op_code,
  output logic [W-1:0]      alu_data1,
  output logic [W-1:0]      alu_data2,
  input  logic [W-1:0]      alu_result
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 4;

  arb_state_t      state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner;
  logic [CW-1:0]   cnt;

  logic [NREQ-1:0] win_grant;
  logic [IW-1:0]   win_idx;
  logic            win_any;
  logic [4:0]      sel_op;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic            trap;
  logic [IW-1:0]   next_ptr;

  alu_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .valid  (req_valid),
    .rr_ptr (rr_ptr),
    .grant  (win_grant),
    .idx    (win_idx),
    .any    (win_any)
  );

  // Operand mux for the winning requester.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IW'(i)) begin
        sel_op = req_op[5*i +: 5];
        sel_a  = req_a[W*i +: W];
        sel_b  = req_b[W*i +: W];
      end
    end
  end

`ifdef ALU_DIVZERO_TRAP_EN
  assign trap = is_div_op(sel_op) && (sel_b == '0);
`else
  assign trap = 1'b0;
`endif

  // Grant is only offered in IDLE; held low while reset is asserted.
  assign req_ready = (rst_n && state == IDLE) ? win_grant : '0;

  assign next_ptr = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      cnt         <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      alu_op_code <= '0;
      alu_data1   <= '0;
      alu_data2   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_any) begin
            owner       <= win_idx;
            alu_op_code <= sel_op;
            alu_data1   <= sel_a;
            alu_data2   <= sel_b;
            cnt         <= CW'(ALU_LAT - 1);
            if (trap) begin
              rsp_data  <= '1;
              rsp_err   <= 1'b1;
              rsp_valid <= win_grant;
              state     <= RESP;
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            rsp_data  <= alu_result;
            rsp_err   <= 1'b0;
            rsp_valid <= NREQ'(1) << owner;
            state     <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= '0;
            rr_ptr    <= next_ptr;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NREQ    = 3;
  localparam int W       = 32;
  localparam int ALU_LAT = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [5*NREQ-1:0] req_op;
  logic [W*NREQ-1:0] req_a;
  logic [W*NREQ-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [W-1:0]      rsp_data;
  logic              rsp_err;
  logic [4:0]        alu_op_code;
  logic [W-1:0]      alu_data1;
  logic [W-1:0]      alu_data2;
  logic [W-1:0]      alu_result;

  alu_arbiter #(.NREQ(NREQ), .W(W), .ALU_LAT(ALU_LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .alu_op_code (alu_op_code),
    .alu_data1   (alu_data1),
    .alu_data2   (alu_data2),
    .alu_result  (alu_result)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- Alu stand-in and its behaviour ----------------
  function automatic logic [W-1:0] alu_fn(input logic [4:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_SG:   return (a > b) ? W'(1) : W'(0);
      OP_SL:   return (a < b) ? W'(1) : W'(0);
      OP_SE:   return (a == b) ? W'(1) : W'(0);
      OP_MULT: return a * b;
      OP_DIV:  return (b == '0) ? '1 : a / b;
      OP_MOD:  return (b == '0) ? a : a % b;
      OP_NOT:  return ~a;
      default: return a ^ b;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_op_code, alu_data1, alu_data2);

  // ---------------- scoreboard ----------------
  typedef struct {
    int           owner;
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] data;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] model_pick(input logic [NREQ-1:0] v, input int ptr);
    logic [NREQ-1:0] g;
    int j;
    g = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = (ptr + k) % NREQ;
      if (v[j]) begin
        g[j] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  function automatic bit model_trap(input logic [4:0] op, input logic [W-1:0] b);
`ifdef ALU_DIVZERO_TRAP_EN
    return (op == OP_DIV || op == OP_MOD) && (b == '0);
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: one op in flight, round-robin pointer advanced past
  // the owner on each completed response, fixed response latency.
  int              cyc = 0;
  bit              m_busy = 0;
  int              m_ptr = 0;
  int              m_owner = 0;
  int              m_resp_cyc = 0;
  logic [NREQ-1:0] m_grant;
  exp_t            m_e;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_busy = 0;
      m_ptr  = 0;
      exp_q.delete();
    end else if (!m_busy) begin
      m_grant = model_pick(req_valid, m_ptr);
      check("grant", 64'(req_ready), 64'(m_grant));
      check("idle_rsp_valid", 64'(rsp_valid), 64'd0);
      if (m_grant != '0) begin
        for (int i = 0; i < NREQ; i++) if (m_grant[i]) m_owner = i;
        m_e.owner = m_owner;
        m_e.op    = req_op[5*m_owner +: 5];
        m_e.a     = req_a[W*m_owner +: W];
        m_e.b     = req_b[W*m_owner +: W];
        m_e.err   = model_trap(m_e.op, m_e.b);
        m_e.data  = m_e.err ? '1 : alu_fn(m_e.op, m_e.a, m_e.b);
        exp_q.push_back(m_e);
        m_busy     = 1;
        m_resp_cyc = cyc + (m_e.err ? 1 : ALU_LAT + 1);
      end
    end else begin
      check("busy_req_ready", 64'(req_ready), 64'd0);
      if (cyc < m_resp_cyc) begin
        check("early_rsp_valid", 64'(rsp_valid), 64'd0);
      end else begin
        check("rsp_valid_owner", 64'(rsp_valid), 64'd1 << m_owner);
        if (rsp_ready[m_owner]) begin
          m_busy = 0;
          m_ptr  = (m_owner + 1) % NREQ;
        end
      end
    end
  end

  // Monitor: compares every presented response against the queue head.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid %0h, expected none", rsp_valid);
      end else begin
        mon_e = exp_q[0];
        check("rsp_owner", 64'(rsp_valid), 64'd1 << mon_e.owner);
        check("rsp_data", 64'(rsp_data), 64'(mon_e.data));
        check("rsp_err", 64'(rsp_err), 64'(mon_e.err));
        check("alu_op_held", 64'(alu_op_code), 64'(mon_e.op));
        check("alu_d1_held", 64'(alu_data1), 64'(mon_e.a));
        check("alu_d2_held", 64'(alu_data2), 64'(mon_e.b));
        if ((rsp_valid & rsp_ready) != '0) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [4:0] ops [13] = '{OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SG, OP_SL, OP_SE,
                           OP_MULT, OP_DIV, OP_MOD, OP_NOT, OP_JL, OP_SW};

  task automatic new_req(input int i);
    req_op[5*i +: 5] = ops[$urandom_range(0, 12)];
    req_a[W*i +: W]  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
    req_b[W*i +: W]  = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
    req_valid[i]     = 1'b1;
  endtask

  task automatic drive_random(input int ncyc);
    logic [NREQ-1:0] acc;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) new_req(i);
        end else if ($urandom_range(0, 30) == 0) begin
          req_valid[i] = 1'b0;
        end
        rsp_ready[i] = ($urandom_range(0, 1) == 1);
      end
    end
  endtask

  task automatic drain();
    @(posedge clk);
    #1;
    req_valid = '0;
    rsp_ready = '1;
    repeat (ALU_LAT + 6) @(posedge clk);
  endtask

  task automatic directed_op(input string name, input int i, input logic [4:0] op,
                             input logic [W-1:0] a, input logic [W-1:0] b,
                             input int lat, input logic [W-1:0] d, input logic e);
    bit got;
    int n;
    @(posedge clk);
    #1;
    req_valid          = '0;
    req_op[5*i +: 5]   = op;
    req_a[W*i +: W]    = a;
    req_b[W*i +: W]    = b;
    req_valid[i]       = 1'b1;
    rsp_ready          = '1;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = req_ready[i];
    end
    check({name, "_grant"}, 64'(got), 64'd1);
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
    got = 0;
    n   = 1;
    while (n <= 20) begin
      @(negedge clk);
      if (rsp_valid[i]) begin
        got = 1;
        break;
      end
      n++;
    end
    check({name, "_rsp_seen"}, 64'(got), 64'd1);
    check({name, "_latency"}, 64'(n), 64'(lat));
    check({name, "_data"}, 64'(rsp_data), 64'(d));
    check({name, "_err"}, 64'(rsp_err), 64'(e));
    @(posedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit got;
    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_alu_op", 64'(alu_op_code), 64'd0);
    check("rst_alu_d1", 64'(alu_data1), 64'd0);
    check("rst_alu_d2", 64'(alu_data2), 64'd0);
    rst_n = 1'b1;

    directed_op("add", 0, OP_ADD, 32'd5, 32'd7, ALU_LAT + 1, 32'd12, 1'b0);
    directed_op("mult", 1, OP_MULT, 32'd6, 32'd7, ALU_LAT + 1, 32'd42, 1'b0);
    directed_op("mod", 2, OP_MOD, 32'd9, 32'd4, ALU_LAT + 1, 32'd1, 1'b0);
`ifdef ALU_DIVZERO_TRAP_EN
    directed_op("divz", 0, OP_DIV, 32'd9, 32'd0, 1, 32'hFFFF_FFFF, 1'b1);
`else
    directed_op("divz", 0, OP_DIV, 32'd9, 32'd0, ALU_LAT + 1, 32'hFFFF_FFFF, 1'b0);
`endif

    drive_random(1500);
    drain();

    // Reset while an op is in EXEC.
    @(posedge clk);
    #1;
    req_op[5*1 +: 5] = OP_ADD;
    req_a[W*1 +: W]  = 32'd1;
    req_b[W*1 +: W]  = 32'd2;
    req_valid        = 3'b010;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = req_ready[1];
    end
    check("exec_rst_grant", 64'(got), 64'd1);
    @(posedge clk);
    #1;
    req_valid = '1;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_ready", 64'(req_ready), 64'd0);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_rsp_data", 64'(rsp_data), 64'd0);
    check("mid_rst_alu_op", 64'(alu_op_code), 64'd0);
    check("mid_rst_alu_d1", 64'(alu_data1), 64'd0);
    check("mid_rst_alu_d2", 64'(alu_data2), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_ready = '1;
    @(negedge clk);
    check("post_rst_grant", 64'(req_ready), 64'b001);
    check("post_rst_no_rsp", 64'(rsp_valid), 64'd0);

    drive_random(300);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
